mc_mem_bridge: RTL and testbench
================================

Name: mc_mem_bridge

Overview:
Memory-side stage directly downstream of the multicycle controller/datapath address mux (AdrSrc-selected address, MemWrite, memory-read strobe).
Converts the core's single-request memory accesses into a req/ack handshake with a variable-latency unified instruction/data memory.
Returns read data in a holding register and reports completion through a done pulse and a busy level.
Flags misaligned accesses and, optionally, handshake timeouts.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; word access only
TIMEOUT_CYCLES, 64, BUSY cycles without ack before abort; used only when MEM_TIMEOUT_EN is defined

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_W  byte address from the core
cpu_wdata  in  DATA_W  store data
cpu_we  in  1  write request; sampled only in IDLE
cpu_re  in  1  read request; sampled only in IDLE
err_clr  in  1  clears sticky error flags
cpu_rdata  out  DATA_W  read-data holding register
cpu_done  out  1  one-cycle completion pulse
cpu_busy  out  1  high whenever state != IDLE
err_misaligned  out  1  sticky misaligned-access flag
err_timeout  out  1  sticky timeout flag; constant 0 without the macro
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, valid while mem_req
mem_addr  out  ADDR_W  word-aligned address, valid while mem_req
mem_wdata  out  DATA_W  write data, valid while mem_req
mem_ack  in  1  memory completion; may be high in the first mem_req cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack on reads

Behaviour:
- Reset values (synchronous; also applies mid-transaction): state=IDLE; all outputs 0, including cpu_rdata; timeout counter 0. A mem_req in flight drops at the reset edge; any late mem_ack is ignored.
- FSM states:
  - IDLE: at an edge with cpu_we|cpu_re:
    - If aligned (cpu_addr[1:0]==0): latch addr/wdata/we; mem_req<=1; mem_we<=cpu_we; go to BUSY.
    - If misaligned: no memory transaction; err_misaligned<=1; cpu_done<=1; go to DONE; cpu_rdata unchanged.
  - BUSY: at an edge with mem_ack=1: mem_req<=0; mem_we<=0; cpu_rdata<=mem_rdata on reads only; cpu_done<=1; go to DONE. mem_addr/mem_wdata/mem_we are held stable while mem_req=1.
  - DONE: cpu_done<=0; go to IDLE unconditionally at the next edge.
- cpu_we and cpu_re high together: the write wins and the read is ignored.
- Requests arriving in BUSY or DONE are ignored, not queued. The core holds its request until it observes cpu_done.
- Latency: request sampled at edge k, mem_ack high in the cycle after edge k gives cpu_done high in the cycle after edge k+1. Minimum 2 cycles; each extra no-ack cycle adds 1.
- mem_ack outside BUSY is ignored.
- cpu_rdata holds its value until the next successful read completes.
- Sticky errors clear at an edge with err_clr=1, unless a new error is set at that same edge; set wins.
- mem_addr[1:0] is always 2'b00.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - The counter increments every BUSY cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: mem_req<=0; err_timeout<=1; cpu_done<=1; go to DONE.
  - On reads, cpu_rdata<={DATA_W{1'b1}}.
  - The counter clears on leaving BUSY.
  - mem_ack at the same edge as expiry counts as a normal completion.
- Undefined: no counter; BUSY waits indefinitely; err_timeout tied to 0.

Test Plan:
- Reset, then read addr 0x0000_0010 with mem_ack at the first req cycle and mem_rdata=0xDEADBEEF -> mem_addr=0x10 and mem_we=0; cpu_done pulses 2 cycles after the request; cpu_rdata=0xDEADBEEF; busy for 2 cycles.
- Write addr 0x24, data 0x12345678, with mem_ack after 3 wait cycles -> mem_req high for 4 cycles with mem_we=1, mem_wdata=0x12345678 stable; one done pulse; cpu_rdata unchanged.
- Read addr 0x13 -> mem_req never rises; err_misaligned=1; done pulses 1 cycle after the request; err_clr=1 returns the flag to 0.
- cpu_we=cpu_re=1 at addr 0x40 -> write issued (mem_we=1). A second request during BUSY is ignored and exactly one transaction occurs.
- rst asserted during BUSY (mem_req=1) -> after that edge mem_req=0, cpu_busy=0, cpu_rdata=0; a mem_ack the following cycle causes no done pulse.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with no ack -> mem_req drops after 4 BUSY cycles; err_timeout=1; cpu_rdata=0xFFFFFFFF; one done pulse.

Source files
------------

// File: rtl/mc_mem_bridge.sv
// rtl/mc_mem_bridge.sv - core-to-memory req/ack bridge; optional handshake timeout via `define MEM_TIMEOUT_EN
module mc_mem_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   input  logic              err_clr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_busy,
   output logic              err_misaligned,
   output logic              err_timeout,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] rdata_q;
   logic              done_q;
   logic              mis_q;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              expire;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             to_q;

   // Count BUSY cycles without ack; flag expiry on the last allowed cycle, clear when leaving BUSY.
   always_comb begin
      cnt_d  = '0;
      expire = 1'b0;
      if (state_q == S_BUSY && !mem_ack) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            expire = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Timeout counter and sticky timeout flag; a new timeout beats err_clr at the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (expire) begin
            to_q <= 1'b1;
         end else if (err_clr) begin
            to_q <= 1'b0;
         end
      end
   end

   assign err_timeout = to_q;
`else
   // Without the timeout feature BUSY never expires; the parameter only matters when enabled.
   assign expire      = (TIMEOUT_CYCLES < 0);
   assign err_timeout = 1'b0;
`endif

   // Request sequencer: IDLE samples the core, BUSY waits for ack or expiry, DONE emits the pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (err_clr) begin
            mis_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (cpu_we || cpu_re) begin
                  if (cpu_addr[1:0] == 2'b00) begin
                     addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                     wdata_q <= cpu_wdata;
                     we_q    <= cpu_we;
                     req_q   <= 1'b1;
                     state_q <= S_BUSY;
                  end else begin
                     mis_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_BUSY: begin
               if (mem_ack || expire) begin
                  if (!we_q) begin
                     rdata_q <= mem_ack ? mem_rdata : {DATA_W{1'b1}};
                  end
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata      = rdata_q;
   assign cpu_done       = done_q;
   assign cpu_busy       = (state_q != S_IDLE);
   assign err_misaligned = mis_q;
   assign mem_req        = req_q;
   assign mem_we         = we_q;
   assign mem_addr       = addr_q;
   assign mem_wdata      = wdata_q;

endmodule

// File: tb/tb_mc_mem_bridge.sv
// tb/tb_mc_mem_bridge.sv - scoreboard bench for mc_mem_bridge
module tb_mc_mem_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_we;
   logic        cpu_re;
   logic        err_clr;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_busy;
   logic        err_misaligned;
   logic        err_timeout;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] rd;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   int          n_pass;
   int          n_total;
   logic [31:0] exp_rd;

   mc_mem_bridge #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_we(cpu_we),
      .cpu_re(cpu_re),
      .err_clr(err_clr),
      .cpu_rdata(cpu_rdata),
      .cpu_done(cpu_done),
      .cpu_busy(cpu_busy),
      .err_misaligned(err_misaligned),
      .err_timeout(err_timeout),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every done pulse consumes one expected completion.
   always @(negedge clk) begin
      if (!rst && cpu_done) begin
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL done_unexpected: got done=1, required no completion");
         end else begin
            exp_t e;
            n_pass++;
            e = sb.pop_front();
            n_total++;
            if (cpu_rdata !== e.rd) $display("FAIL done_rdata: got %h, required %h", cpu_rdata, e.rd);
            else n_pass++;
            n_total++;
            if (err_misaligned !== e.mis) $display("FAIL done_mis: got %b, required %b", err_misaligned, e.mis);
            else n_pass++;
         end
      end
   end

   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                          input logic re, input int wait_n, input logic [31:0] rd, input logic perturb,
                          output int lat, output int reqc, output int busyc, output logic bad,
                          output logic tmo);
      logic prev_req;
      lat = 0; reqc = 0; busyc = 0; bad = 1'b0; tmo = 1'b1; prev_req = 1'b0;
      cpu_addr = addr; cpu_wdata = wdata; cpu_we = we; cpu_re = re;
      mem_rdata = rd; mem_ack = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         lat++;
         if (cpu_busy) busyc++;
         if (cpu_done) begin
            tmo = 1'b0;
            break;
         end
         if (mem_req) begin
            reqc++;
            if (!prev_req && reqc > 1) bad = 1'b1;
            if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== we || (we && mem_wdata !== wdata)) bad = 1'b1;
            if (perturb && reqc == 1) begin
               cpu_addr = addr + 32'h40; cpu_wdata = ~wdata; cpu_we = 1'b0; cpu_re = 1'b1;
            end
            mem_ack = (reqc == wait_n + 1);
         end else begin
            mem_ack = 1'b0;
         end
         prev_req = mem_req;
      end
      cpu_we = 1'b0; cpu_re = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_total++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b, required 0", mem_req); else n_pass++;
      n_total++; if (cpu_busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", cpu_busy); else n_pass++;
      n_total++; if (cpu_done !== 1'b0) $display("FAIL rst_done: got %b, required 0", cpu_done); else n_pass++;
      n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_rdata: got %h, required 0", cpu_rdata); else n_pass++;
      n_total++; if (err_misaligned !== 1'b0) $display("FAIL rst_mis: got %b, required 0", err_misaligned); else n_pass++;
      n_total++; if (err_timeout !== 1'b0) $display("FAIL rst_to: got %b, required 0", err_timeout); else n_pass++;
      n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_addr: got %h, required 0", mem_addr); else n_pass++;
      rst = 1'b0;
      exp_rd = 32'h0;
   endtask

   task automatic test_read_fast();
      int lat, reqc, busyc; logic bad, tmo;
      exp_rd = 32'hDEADBEEF;
      sb.push_back('{rd: exp_rd, mis: 1'b0});
      run_txn(32'h10, 32'h0, 1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b0, lat, reqc, busyc, bad, tmo);
      n_total++; if (tmo !== 1'b0) $display("FAIL rd_timeout: got no done, required done"); else n_pass++;
      n_total++; if (lat != 2) $display("FAIL rd_latency: got %0d, required 2", lat); else n_pass++;
      n_total++; if (reqc != 1) $display("FAIL rd_req_cycles: got %0d, required 1", reqc); else n_pass++;
      n_total++; if (busyc != 2) $display("FAIL rd_busy_cycles: got %0d, required 2", busyc); else n_pass++;
      n_total++; if (bad !== 1'b0) $display("FAIL rd_mem_fields: got bad=%b, required 0", bad); else n_pass++;
      @(negedge clk);
      n_total++; if ({cpu_done, cpu_busy} !== 2'b00) $display("FAIL rd_idle: got done/busy=%b, required 00", {cpu_done, cpu_busy}); else n_pass++;
   endtask

   task automatic test_write_wait();
      int lat, reqc, busyc; logic bad, tmo;
      sb.push_back('{rd: exp_rd, mis: 1'b0});
      run_txn(32'h24, 32'h12345678, 1'b1, 1'b0, 3, 32'hCAFEF00D, 1'b0, lat, reqc, busyc, bad, tmo);
      n_total++; if (tmo !== 1'b0) $display("FAIL wr_timeout: got no done, required done"); else n_pass++;
      n_total++; if (reqc != 4) $display("FAIL wr_req_cycles: got %0d, required 4", reqc); else n_pass++;
      n_total++; if (lat != 5) $display("FAIL wr_latency: got %0d, required 5", lat); else n_pass++;
      n_total++; if (bad !== 1'b0) $display("FAIL wr_mem_fields: got bad=%b, required 0", bad); else n_pass++;
      @(negedge clk);
      n_total++; if (cpu_done !== 1'b0) $display("FAIL wr_done_width: got %b, required 0", cpu_done); else n_pass++;
   endtask

   task automatic test_misaligned();
      int lat, reqc, busyc; logic bad, tmo;
      sb.push_back('{rd: exp_rd, mis: 1'b1});
      run_txn(32'h13, 32'h0, 1'b0, 1'b1, 0, 32'h55555555, 1'b0, lat, reqc, busyc, bad, tmo);
      n_total++; if (tmo !== 1'b0) $display("FAIL mis_timeout: got no done, required done"); else n_pass++;
      n_total++; if (lat != 1) $display("FAIL mis_latency: got %0d, required 1", lat); else n_pass++;
      n_total++; if (reqc != 0) $display("FAIL mis_req_cycles: got %0d, required 0", reqc); else n_pass++;
      @(negedge clk);
      n_total++; if (err_misaligned !== 1'b1) $display("FAIL mis_sticky: got %b, required 1", err_misaligned); else n_pass++;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_total++; if (err_misaligned !== 1'b0) $display("FAIL mis_clear: got %b, required 0", err_misaligned); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat, reqc, busyc; logic bad, tmo;
      sb.push_back('{rd: exp_rd, mis: 1'b0});
      run_txn(32'h40, 32'hA5A5_0F0F, 1'b1, 1'b1, 2, 32'h11111111, 1'b1, lat, reqc, busyc, bad, tmo);
      n_total++; if (tmo !== 1'b0) $display("FAIL dual_timeout: got no done, required done"); else n_pass++;
      n_total++; if (reqc != 3) $display("FAIL dual_req_cycles: got %0d, required 3", reqc); else n_pass++;
      n_total++; if (bad !== 1'b0) $display("FAIL dual_mem_fields: got bad=%b, required 0", bad); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (mem_req !== 1'b0) $display("FAIL dual_extra_req: got %b, required 0", mem_req); else n_pass++;
   endtask

   task automatic test_reset_mid();
      cpu_addr = 32'h50; cpu_re = 1'b1; mem_ack = 1'b0;
      @(negedge clk);
      n_total++; if (mem_req !== 1'b1) $display("FAIL rmid_req_up: got %b, required 1", mem_req); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; cpu_re = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
      exp_rd = 32'h0;
      n_total++; if (mem_req !== 1'b0) $display("FAIL rmid_req: got %b, required 0", mem_req); else n_pass++;
      n_total++; if (cpu_busy !== 1'b0) $display("FAIL rmid_busy: got %b, required 0", cpu_busy); else n_pass++;
      n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rmid_rdata: got %h, required 0", cpu_rdata); else n_pass++;
      @(negedge clk);
      mem_ack = 1'b0;
      n_total++; if (cpu_done !== 1'b0) $display("FAIL rmid_late_ack: got done=%b, required 0", cpu_done); else n_pass++;
      n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rmid_rdata_hold: got %h, required 0", cpu_rdata); else n_pass++;
   endtask

   task automatic test_timeout();
      int lat, reqc, busyc; logic bad, tmo;
`ifdef MEM_TIMEOUT_EN
      exp_rd = 32'hFFFFFFFF;
      sb.push_back('{rd: exp_rd, mis: 1'b0});
      run_txn(32'h60, 32'h0, 1'b0, 1'b1, 1000, 32'h12121212, 1'b0, lat, reqc, busyc, bad, tmo);
      n_total++; if (tmo !== 1'b0) $display("FAIL to_no_done: got no done, required done"); else n_pass++;
      n_total++; if (reqc != 4) $display("FAIL to_req_cycles: got %0d, required 4", reqc); else n_pass++;
      n_total++; if (err_timeout !== 1'b1) $display("FAIL to_flag: got %b, required 1", err_timeout); else n_pass++;
      @(negedge clk);
`else
      lat = 0; reqc = 0; busyc = 0; bad = 1'b0; tmo = 1'b0;
      n_total++; if (err_timeout !== 1'b0) $display("FAIL to_tied: got %b, required 0", err_timeout); else n_pass++;
`endif
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
      err_clr = 1'b0; mem_ack = 1'b0; mem_rdata = '0; exp_rd = '0;
      test_reset();
      test_read_fast();
      test_write_wait();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      repeat (2) @(negedge clk);
      n_total++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
